// File: rtl/irq_pkg.sv
// Shared types, vector constants and vector arithmetic for the interrupt
// arbiter / vector generator.
package irq_pkg;

  typedef bit [2:0] src_idx_type;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RES = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  // Vector of source idx, counted downward from top; wraps modulo 2^16.
  function automatic logic [15:0] vec_of(input src_idx_type idx,
                                         input logic [15:0] top,
                                         input int unsigned stride);
    logic [31:0] off;
    off = stride * 32'(idx);
    return top - off[15:0];
  endfunction

endpackage

// File: rtl/irq_vector_ctrl_if.sv
// Core-side bus of irq_vector_ctrl: raw lines, sample handshake, break result.
// Status outputs exist only when IRQ_VECTOR_CTRL_STATUS_EN is defined.
interface irq_vector_ctrl_if #(parameter int N_SRC = 2);
  logic [N_SRC-1:0] I_irq_n;
  logic             I_ready;
  logic             I_iflag;
  logic             I_sample;
  logic             O_take;
  logic             O_reset_seq;
  logic [15:0]      O_vector;
  logic [2:0]       O_src;
`ifdef IRQ_VECTOR_CTRL_STATUS_EN
  logic [N_SRC-1:0] O_pend;
  logic             O_nest;

  modport master (output I_irq_n, I_ready, I_iflag, I_sample,
                  input  O_take, O_reset_seq, O_vector, O_src, O_pend, O_nest);
  modport slave  (input  I_irq_n, I_ready, I_iflag, I_sample,
                  output O_take, O_reset_seq, O_vector, O_src, O_pend, O_nest);
`else
  modport master (output I_irq_n, I_ready, I_iflag, I_sample,
                  input  O_take, O_reset_seq, O_vector, O_src);
  modport slave  (input  I_irq_n, I_ready, I_iflag, I_sample,
                  output O_take, O_reset_seq, O_vector, O_src);
`endif
endinterface

// File: rtl/irq_sync_edge.sv
// One interrupt line: input synchroniser followed by either a falling-edge
// pending latch or a plain active-low level decode.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b0
) (
  input  logic I_clock,
  input  logic I_reset,
  input  logic irq_n,
  input  logic clr,
  output logic pend
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   s;

  // Synchroniser stages; idle level of an active-low line is 1
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      sync_p <= '1;
    end else begin
      sync_p[0] <= irq_n;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p[k] <= sync_p[k-1];
    end
  end

  assign s = sync_p[SYNC_STAGES-1];

  if (EDGE) begin : g_edge
    logic prev_p;
    logic pend_p;

    // A new edge beats a simultaneous clear so no edge is ever lost
    always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
        prev_p <= 1'b1;
        pend_p <= 1'b0;
      end else begin
        prev_p <= s;
        if (prev_p && !s)  pend_p <= 1'b1;
        else if (clr)      pend_p <= 1'b0;
      end
    end

    assign pend = pend_p;
  end else begin : g_level
    logic unused_clr;
    assign unused_clr = clr;
    assign pend       = ~s;
  end

endmodule

// File: rtl/irq_vector_ctrl.sv
// Interrupt arbiter and vector generator for the 2A03-class core.
// Optional status outputs (O_pend, O_nest) under IRQ_VECTOR_CTRL_STATUS_EN.
module irq_vector_ctrl
  import irq_pkg::*;
#(
  parameter int               N_SRC       = 2,
  parameter logic [N_SRC-1:0] EDGE_MASK   = 2'b10,
  parameter logic [N_SRC-1:0] NMI_MASK    = 2'b10,
  parameter int               SYNC_STAGES = 2,
  parameter logic [15:0]      VEC_TOP     = VEC_IRQ,
  parameter int unsigned      VEC_STRIDE  = 4,
  parameter logic [15:0]      RES_VEC     = VEC_RES
) (
  input logic              I_clock,
  input logic              I_reset,
  irq_vector_ctrl_if.slave bus
);

  if (N_SRC < 1 || N_SRC > 8) begin : g_bad_n_src
    $error("irq_vector_ctrl: N_SRC must be in 1..8");
  end

  logic [N_SRC-1:0] pend, elig, clr;
  logic             any_elig, sample_ev, res_pend;
  src_idx_type      winner;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE        (EDGE_MASK[g])
    ) u_sync_edge (
      .I_clock (I_clock),
      .I_reset (I_reset),
      .irq_n   (bus.I_irq_n[g]),
      .clr     (clr[g]),
      .pend    (pend[g])
    );
  end

  // Arbitration: highest eligible index wins; reset sequence outranks all
  always_comb begin
    elig      = pend & (NMI_MASK | {N_SRC{~bus.I_iflag}});
    any_elig  = |elig;
    sample_ev = bus.I_sample & bus.I_ready;
    winner    = '0;
    for (int i = 0; i < N_SRC; i++)
      if (elig[i]) winner = src_idx_type'(i);
    clr = '0;
    for (int i = 0; i < N_SRC; i++)
      clr[i] = sample_ev & ~res_pend & elig[i] & EDGE_MASK[i] & (winner == src_idx_type'(i));
  end

  logic        take_p1, reset_seq_p1;
  logic [15:0] vector_p1;
  src_idx_type src_p1;

  // Result stage: updated only on an accepted sample strobe
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      res_pend     <= 1'b1;
      take_p1      <= 1'b0;
      reset_seq_p1 <= 1'b0;
      vector_p1    <= RES_VEC;
      src_p1       <= '0;
    end else if (sample_ev) begin
      if (res_pend) begin
        res_pend     <= 1'b0;
        take_p1      <= 1'b1;
        reset_seq_p1 <= 1'b1;
        vector_p1    <= RES_VEC;
        src_p1       <= '0;
      end else if (any_elig) begin
        take_p1      <= 1'b1;
        reset_seq_p1 <= 1'b0;
        vector_p1    <= vec_of(winner, VEC_TOP, VEC_STRIDE);
        src_p1       <= winner;
      end else begin
        take_p1      <= 1'b0;
        reset_seq_p1 <= 1'b0;
        vector_p1    <= VEC_TOP;
        src_p1       <= '0;
      end
    end
  end

  assign bus.O_take      = take_p1;
  assign bus.O_reset_seq = reset_seq_p1;
  assign bus.O_vector    = vector_p1;
  assign bus.O_src       = src_p1;

`ifdef IRQ_VECTOR_CTRL_STATUS_EN
  logic [N_SRC-1:0] pend_p1;
  logic             nest_p1;
  logic [3:0]       n_elig;

  always_comb begin
    n_elig = '0;
    for (int i = 0; i < N_SRC; i++) n_elig = n_elig + 4'(elig[i]);
  end

  // Status stage: nest means another eligible source is left behind the taken one
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      pend_p1 <= '0;
      nest_p1 <= 1'b0;
    end else begin
      pend_p1 <= pend;
      if (sample_ev) nest_p1 <= res_pend ? any_elig : (n_elig >= 4'd2);
    end
  end

  assign bus.O_pend = pend_p1;
  assign bus.O_nest = nest_p1;
`endif

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Randomised scoreboard bench for irq_vector_ctrl with a behavioural reference model.
module tb_irq_vector_ctrl;

  localparam int N      = 2;
  localparam int SYNC_N = 2;
  localparam logic [N-1:0] EDGE_M = 2'b10;
  localparam logic [N-1:0] NMI_M  = 2'b10;

  typedef struct packed {
    logic        take;
    logic        rseq;
    logic [15:0] vec;
    logic [2:0]  src;
  } exp_t;

  localparam exp_t EXP_RESET = '{take: 1'b0, rseq: 1'b0, vec: 16'hFFFC, src: 3'd0};

  logic I_clock = 1'b0;
  logic I_reset = 1'b0;

  irq_vector_ctrl_if #(.N_SRC(N)) bus ();

  irq_vector_ctrl #(
    .N_SRC       (N),
    .EDGE_MASK   (EDGE_M),
    .NMI_MASK    (NMI_M),
    .SYNC_STAGES (SYNC_N),
    .VEC_TOP     (16'hFFFE),
    .VEC_STRIDE  (4),
    .RES_VEC     (16'hFFFC)
  ) dut (
    .I_clock (I_clock),
    .I_reset (I_reset),
    .bus     (bus.slave)
  );

  always #5 I_clock = ~I_clock;

  exp_t q[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  // Reference model: line history as a delay line, pending edges as a bit set
  logic [N-1:0] hist [0:SYNC_N];
  logic [N-1:0] pe;
  bit           res_pend;

  task automatic model_reset();
    for (int j = 0; j <= SYNC_N; j++) hist[j] = '1;
    pe       = '0;
    res_pend = 1'b1;
    q.delete();
    cur      = EXP_RESET;
  endtask

  initial begin
    logic [N-1:0] s, prv, pd, el, clr_m;
    int   w;
    exp_t e;
    model_reset();
    forever begin
      @(posedge I_clock or negedge I_reset);
      if (!I_reset) begin
        model_reset();
      end else begin
        s   = hist[SYNC_N-1];
        prv = hist[SYNC_N];
        for (int i = 0; i < N; i++) begin
          pd[i] = EDGE_M[i] ? pe[i] : ~s[i];
          el[i] = pd[i] & (NMI_M[i] | ~bus.I_iflag);
        end
        clr_m = '0;
        if (bus.I_sample && bus.I_ready) begin
          w = -1;
          for (int i = 0; i < N; i++) if (el[i]) w = i;
          if (res_pend) begin
            e = '{take: 1'b1, rseq: 1'b1, vec: 16'hFFFC, src: 3'd0};
            res_pend = 1'b0;
          end else if (w >= 0) begin
            e = '{take: 1'b1, rseq: 1'b0, vec: 16'(32'hFFFE - 4 * w), src: 3'(w)};
            if (EDGE_M[w]) clr_m[w] = 1'b1;
          end else begin
            e = '{take: 1'b0, rseq: 1'b0, vec: 16'hFFFE, src: 3'd0};
          end
          q.push_back(e);
        end
        for (int i = 0; i < N; i++)
          if (EDGE_M[i]) begin
            if (prv[i] && !s[i]) pe[i] = 1'b1;
            else if (clr_m[i])   pe[i] = 1'b0;
          end
        for (int j = SYNC_N; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = bus.I_irq_n;
      end
    end
  end

  // Monitor: pops a new expectation when one was issued, otherwise checks hold
  initial begin
    forever begin
      @(posedge I_clock);
      #3;
      if (q.size() > 0) cur = q.pop_front();
      n_tests++;
      if (bus.O_take !== cur.take || bus.O_reset_seq !== cur.rseq ||
          bus.O_vector !== cur.vec || bus.O_src !== cur.src) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got take=%b rseq=%b vec=%h src=%0d, want take=%b rseq=%b vec=%h src=%0d",
                 $time, bus.O_take, bus.O_reset_seq, bus.O_vector, bus.O_src,
                 cur.take, cur.rseq, cur.vec, cur.src);
      end
    end
  end

  // Watchdog: the run must complete within a bounded time
  initial begin
    #2000000;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout t=%0t: bench did not finish", $time);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  task automatic check_reset_state(input string tag);
    n_tests++;
    if (bus.O_take !== 1'b0 || bus.O_reset_seq !== 1'b0 ||
        bus.O_vector !== 16'hFFFC || bus.O_src !== 3'd0) begin
      n_fail++;
      $display("FAIL reset state (%s) t=%0t: got take=%b rseq=%b vec=%h src=%0d",
               tag, $time, bus.O_take, bus.O_reset_seq, bus.O_vector, bus.O_src);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge I_clock);
  endtask

  task automatic do_sample();
    @(negedge I_clock) bus.I_sample = 1'b1;
    @(negedge I_clock) bus.I_sample = 1'b0;
  endtask

  task automatic pulse_src1(input int len);
    @(negedge I_clock) bus.I_irq_n[1] = 1'b0;
    idle(len);
    bus.I_irq_n[1] = 1'b1;
  endtask

  initial begin
    bus.I_irq_n  = '1;
    bus.I_ready  = 1'b1;
    bus.I_iflag  = 1'b1;
    bus.I_sample = 1'b0;
    idle(3);
    check_reset_state("initial");
    I_reset = 1'b1;
    idle(2);

    // Reset sequence, then nothing pending
    do_sample();
    do_sample();

    // Level source 0: masked by I flag, then taken
    bus.I_irq_n[0] = 1'b0;
    idle(4);
    do_sample();
    bus.I_iflag = 1'b0;
    do_sample();

    // Edge source 1 beats blocked level source 0
    bus.I_iflag = 1'b1;
    pulse_src1(3);
    idle(4);
    do_sample();
    do_sample();

    // Edge arriving in the clock of its clearing sample
    pulse_src1(3);
    idle(4);
    for (int d = 0; d < 4; d++) begin
      bus.I_irq_n[1] = 1'b0;
      idle(d);
      do_sample();
      bus.I_irq_n[1] = 1'b1;
      idle(4);
      do_sample();
      do_sample();
    end

    // Ready low: samples ignored while an edge latches
    bus.I_ready = 1'b0;
    pulse_src1(3);
    do_sample();
    idle(3);
    do_sample();
    bus.I_ready = 1'b1;
    do_sample();

    // Mid-operation reset with source 1 pending
    pulse_src1(3);
    idle(4);
    @(negedge I_clock) I_reset = 1'b0;
    #1;
    check_reset_state("mid-operation");
    idle(2);
    I_reset = 1'b1;
    idle(2);
    do_sample();
    do_sample();
    bus.I_irq_n[0] = 1'b1;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge I_clock);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) bus.I_irq_n[i] = ~bus.I_irq_n[i];
      if ($urandom_range(0, 9) == 0) bus.I_iflag = ~bus.I_iflag;
      bus.I_sample = ($urandom_range(0, 3) == 0);
      bus.I_ready  = ($urandom_range(0, 4) != 0);
      I_reset      = ($urandom_range(0, 399) != 0);
    end
    @(negedge I_clock);
    I_reset      = 1'b1;
    bus.I_sample = 1'b0;
    idle(4);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_vector_ctrl.md
Name: irq_vector_ctrl

Overview:
- Parametrised interrupt arbiter and vector generator for the 2A03-class CPU core.
- Replaces the core's hard-wired RES/NMI/IRQ logic with N_SRC sources. Each source has its own trigger mode, maskability and vector slot.
- Sits beside the core sequencer. The core strobes I_sample at each opcode-fetch boundary and consumes O_take / O_vector / O_reset_seq on the following cycles.

Parameters:
- N_SRC, 2, number of interrupt sources (1..8); the reset sequence is extra and implicit.
- EDGE_MASK, 2'b10, bit i=1: source i is falling-edge latched; bit i=0: active-low level.
- NMI_MASK, 2'b10, bit i=1: source i ignores I_iflag.
- SYNC_STAGES, 2, input synchroniser depth (1..3).
- VEC_TOP, 16'hFFFE, vector address of source 0.
- VEC_STRIDE, 4, vector of source i = VEC_TOP - VEC_STRIDE*i (mod 2^16).
- RES_VEC, 16'hFFFC, reset vector.

Ports:
- I_clock  in  1  system clock
- I_reset  in  1  asynchronous, active-low reset
- I_ready  in  1  core ready; gates sampling only
- I_irq_n  in  N_SRC  raw interrupt lines, active-low
- I_iflag  in  1  processor I flag (1 = maskable sources blocked)
- I_sample  in  1  one-clock strobe at the opcode-fetch boundary
- O_take  out  1  forced break selected at the last sample
- O_reset_seq  out  1  the taken break is the reset sequence
- O_vector  out  16  vector low-byte address; the core reads O_vector+1 for the high byte
- O_src  out  3  index of the taken source (0 when none or reset)

Behaviour:
- Reset (I_reset low, async): synchroniser flops = 1, edge pending = 0, res_pend = 1, O_take = 0, O_reset_seq = 0, O_vector = RES_VEC, O_src = 0.
- Synchroniser: each I_irq_n[i] passes through SYNC_STAGES flops, giving s[i]. Previous value prev[i] is kept; prev resets to 1.
- Edge sources: pend[i] sets when prev[i]=1 and s[i]=0, regardless of I_ready, I_iflag or I_sample.
- Level sources: pend[i] = ~s[i], combinational, never latched.
- Eligible: elig[i] = pend[i] & (NMI_MASK[i] | ~I_iflag).
- Sample event: I_sample & I_ready. All outputs update only on this event and hold otherwise. Latency is one clock: outputs are valid on the clock after the strobe.
- Priority on sample:
  - res_pend=1: O_take=1, O_reset_seq=1, O_vector=RES_VEC, O_src=0; res_pend clears. No edge pending clears.
  - Else, if any elig: winner = highest eligible index. O_take=1, O_reset_seq=0, O_vector = VEC_TOP - VEC_STRIDE*winner, O_src=winner. If the winner is an edge source, its pend clears.
  - Else: O_take=0, O_reset_seq=0, O_vector=VEC_TOP (BRK/soft vector), O_src=0.
- Simultaneous new edge and clear on the same source in the same clock: the set wins and pend stays 1.
- Non-winning edge pends are retained across samples.
- I_ready low: edges still latch; I_sample is ignored.
- Mid-operation reset: everything returns to reset values immediately and res_pend=1 again.
- Width rules:
  - Vector arithmetic is 16-bit and wraps.
  - O_src is zero-extended to 3 bits.
  - An N_SRC outside 1..8 is an elaboration error ($error).

Optional Feature:
- Macro IRQ_VECTOR_CTRL_STATUS_EN.
- When defined: adds output O_pend[N_SRC-1:0] (registered, one clock after pend, reset 0) and output O_nest (1 when O_take and a second eligible source remained pending at the sample). Intended for the Verilator DPI debug dump.
- When undefined: neither port exists and no extra flops are built.

Decomposition:
- Shared package irq_pkg:
  - typedef src_idx_type (bit[2:0]).
  - Constants VEC_NMI=16'hFFFA, VEC_RES=16'hFFFC, VEC_IRQ=16'hFFFE.
  - Function vec_of(idx, top, stride).
- One natural sub-module, irq_sync_edge: the per-source synchroniser plus edge/level pending logic, instantiated N_SRC times via generate.

Test Plan:
- Reset release, then I_sample -> O_take=1, O_reset_seq=1, O_vector=16'hFFFC. Second sample with no sources -> O_take=0, O_vector=16'hFFFE.
- Level source 0 held low, I_iflag=1, sample -> O_take=0. Set I_iflag=0, sample -> O_take=1, O_vector=16'hFFFE, O_src=0.
- Source 1 edge (1->0 for 3 clocks, back to 1), with I_iflag=1 and source 0 low, sample -> O_vector=16'hFFFA, O_src=1. Next sample -> source 0 blocked, O_take=0.
- Source 1 edge timed to land in the same clock as its clearing sample -> pend stays 1; next sample takes source 1 again.
- I_ready=0 with I_sample pulses while a source 1 edge arrives -> outputs unchanged. First sample with I_ready=1 -> O_take=1, O_src=1.
- I_reset asserted between samples while source 1 is pending -> O_take=0 at once, pending lost. First sample after release -> O_reset_seq=1.
